// File: rtl/carry_save_resolve.sv
// Resolves a redundant carry-save pair r0/r1 into one binary sum, one Chunk-bit
// slice per cycle with a registered ripple carry between slices.
module carry_save_resolve #(
    parameter int Size    = 3072,
    parameter int Size_bi = 64,
    parameter int Chunk   = 64,
    localparam int W      = Size + Size_bi + 2,
    localparam int N      = (W + Chunk - 1) / Chunk,
    localparam int CW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] r0,
    input  logic [W-1:0] r1,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W:0]   sum
);

    localparam int PW = N * Chunk;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   op0_r;
    logic [PW-1:0]   op1_r;
    logic [PW-1:0]   acc_r;
    logic            carry_r;
    logic [CW-1:0]   cnt_r;

    logic [Chunk-1:0] a_s;
    logic [Chunk-1:0] b_s;
    logic [Chunk:0]   slice_s;
    logic             acc_pad_unused_s;

    // One chunk of the ripple: selected operand slices plus the carry from the previous chunk
    always_comb begin
        a_s     = op0_r[cnt_r * Chunk +: Chunk];
        b_s     = op1_r[cnt_r * Chunk +: Chunk];
        slice_s = {1'b0, a_s} + {1'b0, b_s} + {{Chunk{1'b0}}, carry_r};
    end

    // Sequencer: capture operands on acceptance, resolve one chunk per ADD cycle, pulse DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            op0_r   <= '0;
            op1_r   <= '0;
            acc_r   <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (en) begin
                        op0_r   <= {{(PW-W){1'b0}}, r0};
                        op1_r   <= {{(PW-W){1'b0}}, r1};
                        acc_r   <= '0;
                        carry_r <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= ADD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    acc_r[cnt_r * Chunk +: Chunk] <= slice_s[Chunk-1:0];
                    carry_r <= slice_s[Chunk];
                    if (cnt_r == LAST_IDX) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Padding bits above the final carry are structurally zero and never observed
    assign acc_pad_unused_s = ^acc_r[PW-1:W+1];

    assign ready = (state_r == IDLE);
    assign busy  = (state_r == ADD);
    assign done  = (state_r == DONE);
    assign sum   = acc_r[W:0];

endmodule
